// File: rtl/riscv_core_icache_axi_refill.sv
// I-cache refill engine: turns a line-aligned miss request into a single
// AXI4 INCR read burst. It assembles the returned beats into one cache line
// and reports completion with a one-cycle done pulse and an error flag.
module riscv_core_icache_axi_refill #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic                      o_mem_err,
  output logic [LINE_WIDTH-1:0]     o_line_data,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [3:0]                o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  // Clears the byte-offset bits of a 32-byte line address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(31);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic            err_flag;
  logic            beat_fire;
  logic            is_last;
  logic            beat_err;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst = 2'b01;
  assign o_arid    = AXI_ID;

  // Per-beat handshake and protocol error detection. An RLAST flag on the
  // wrong beat is an error, but the beat counter still decides when the burst ends.
  always_comb begin
    beat_fire = i_rvalid & o_rready;
    is_last   = (beat_cnt == LAST_BEAT);
    beat_err  = (i_rresp != 2'b00) | (i_rlast != is_last);
  end

  // Refill FSM with all handshake and result outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_arvalid   <= 1'b0;
      o_rready    <= 1'b0;
      o_mem_done  <= 1'b0;
      o_mem_err   <= 1'b0;
      o_araddr    <= '0;
      o_line_data <= '0;
      beat_cnt    <= '0;
      err_flag    <= 1'b0;
    end else begin
      o_mem_done <= 1'b0;
      o_mem_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_mem_req) begin
            o_araddr  <= i_addr & LINE_MASK;
            err_flag  <= 1'b0;
            beat_cnt  <= '0;
            o_arvalid <= 1'b1;
            state     <= S_AR;
          end
        end
        S_AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (beat_fire) begin
            o_line_data[beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
            beat_cnt <= beat_cnt + 1'b1;
            err_flag <= err_flag | beat_err;
            if (is_last) begin
              o_rready   <= 1'b0;
              o_mem_done <= 1'b1;
              o_mem_err  <= err_flag | beat_err;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The request is ignored here; the controller drops it on seeing done.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_axi_refill.sv
// Directed bench for the I-cache AXI refill engine. Inputs change 1ns after
// each rising edge, and outputs are sampled at that same point.
module tb_riscv_core_icache_axi_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req;
  logic [63:0]  addr;
  logic         mem_done;
  logic         mem_err;
  logic [255:0] line_data;
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid;
  logic         rready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  int n_vec = 0;
  int n_err = 0;

  riscv_core_icache_axi_refill dut (
    .i_clk(clk), .i_rst(rst), .i_mem_req(mem_req), .i_addr(addr),
    .o_mem_done(mem_done), .o_mem_err(mem_err), .o_line_data(line_data),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
    .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst), .o_arid(arid),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata),
    .i_rresp(rresp), .i_rlast(rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_word(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(k * 8'h11);
    return {8{b}};
  endfunction

  // Runs one refill: ar_wait cycles of ARREADY low, gaps[k] idle cycles
  // before beat k, with resp[k] and last[k] driven on beat k.
  task automatic run_burst(input string name, input logic [63:0] a,
                           input int ar_wait, input logic [3:0][3:0] gaps,
                           input logic [3:0][1:0] resp, input logic [3:0] last,
                           input logic [7:0] base, input logic exp_err);
    logic [63:0]  exp_addr;
    logic [255:0] exp_line;
    int           cycles;
    int           exp_cycles;
    exp_addr   = {a[63:5], 5'b0};
    exp_cycles = 2 + ar_wait + 4;
    for (int k = 0; k < 4; k++) begin
      exp_line[k*64 +: 64] = beat_word(base, k);
      exp_cycles += int'(gaps[k]);
    end
    mem_req = 1'b1;
    addr    = a;
    arready = 1'b0;
    step();
    cycles = 1;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== exp_addr) begin
      n_err++;
      $display("FAIL %s ar_start: arvalid=%b araddr=%h required arvalid=1 araddr=%h",
               name, arvalid, araddr, exp_addr);
    end
    for (int w = 0; w < ar_wait; w++) begin
      step();
      cycles++;
      n_vec++;
      if (arvalid !== 1'b1 || araddr !== exp_addr) begin
        n_err++;
        $display("FAIL %s ar_hold%0d: arvalid=%b araddr=%h required arvalid=1 araddr=%h",
                 name, w, arvalid, araddr, exp_addr);
      end
    end
    arready = 1'b1;
    step();
    cycles++;
    arready = 1'b0;
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ar_handshake: arvalid=%b rready=%b required arvalid=0 rready=1",
               name, arvalid, rready);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[k]); g++) begin
        step();
        cycles++;
      end
      rvalid = 1'b1;
      rdata  = beat_word(base, k);
      rresp  = resp[k];
      rlast  = last[k];
      step();
      cycles++;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (k < 3) begin
        n_vec++;
        if (mem_done !== 1'b0 || rready !== 1'b1) begin
          n_err++;
          $display("FAIL %s early_done_beat%0d: done=%b rready=%b required done=0 rready=1",
                   name, k, mem_done, rready);
        end
      end
    end
    mem_req = 1'b0;
    n_vec++;
    if (mem_done !== 1'b1 || mem_err !== exp_err || rready !== 1'b0) begin
      n_err++;
      $display("FAIL %s done: done=%b err=%b rready=%b required done=1 err=%b rready=0",
               name, mem_done, mem_err, rready, exp_err);
    end
    n_vec++;
    if (line_data !== exp_line) begin
      n_err++;
      $display("FAIL %s line: got %h required %h", name, line_data, exp_line);
    end
    n_vec++;
    if (cycles !== exp_cycles) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, cycles, exp_cycles);
    end
    step();
    n_vec++;
    if (mem_done !== 1'b0 || mem_err !== 1'b0 || arvalid !== 1'b0 || line_data !== exp_line) begin
      n_err++;
      $display("FAIL %s after_done: done=%b err=%b arvalid=%b line_held=%b required 0 0 0 1",
               name, mem_done, mem_err, arvalid, line_data === exp_line);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_req = 1'b0; addr = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    step(); step();
    rst = 1'b0;
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || mem_done !== 1'b0 || mem_err !== 1'b0 ||
        araddr !== 64'd0 || line_data !== 256'd0) begin
      n_err++;
      $display("FAIL reset_values: arvalid=%b rready=%b done=%b err=%b araddr=%h line=%h required all zero",
               arvalid, rready, mem_done, mem_err, araddr, line_data);
    end
    n_vec++;
    if (arlen !== 8'd3 || arsize !== 3'd3 || arburst !== 2'b01 || arid !== 4'd0) begin
      n_err++;
      $display("FAIL ar_constants: arlen=%0d arsize=%0d arburst=%0d arid=%0d required 3 3 1 0",
               arlen, arsize, arburst, arid);
    end
  endtask

  task automatic test_basic();
    run_burst("basic", 64'h0000_0000_8000_1234, 0, '0, '0, 4'b1000, 8'h11, 1'b0);
  endtask

  task automatic test_ar_stall();
    run_burst("ar_stall", 64'h0000_0001_0000_0FFF, 3, '0, '0, 4'b1000, 8'h05, 1'b0);
  endtask

  task automatic test_r_gaps();
    run_burst("r_gaps", 64'hFFFF_FFFF_FFFF_FFE0, 0, {4'd5, 4'd2, 4'd0, 4'd0},
              '0, 4'b1000, 8'h21, 1'b0);
  endtask

  task automatic test_rresp_err();
    run_burst("rresp_err", 64'h0000_0000_0000_0040, 1, '0, {2'b00, 2'b10, 2'b00, 2'b00},
              4'b1000, 8'h30, 1'b1);
    run_burst("clean_after_err", 64'h0000_0000_0000_0060, 0, '0, '0, 4'b1000, 8'h40, 1'b0);
  endtask

  task automatic test_rlast_err();
    run_burst("rlast_early", 64'h0000_0000_1234_5678, 0, '0, '0, 4'b0010, 8'h50, 1'b1);
    run_burst("rlast_missing", 64'h0000_0000_1234_5698, 0, '0, '0, 4'b0000, 8'h60, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 64'h0000_0000_0000_1000, 0, '0, '0, 4'b1000, 8'h70, 1'b0);
    run_burst("b2b_b", 64'h0000_0000_0000_2010, 0, '0, '0, 4'b1000, 8'h80, 1'b0);
  endtask

  task automatic test_mid_reset();
    mem_req = 1'b1;
    addr    = 64'h0000_0000_8000_1234;
    arready = 1'b1;
    step();
    step();
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = beat_word(8'h90, k); rlast = 1'b0;
      step();
    end
    rvalid  = 1'b0;
    mem_req = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || line_data !== 256'd0 || mem_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: arvalid=%b rready=%b done=%b line=%h required all zero",
               arvalid, rready, mem_done, line_data);
    end
    run_burst("after_reset", 64'h0000_0000_8000_1234, 0, '0, '0, 4'b1000, 8'hA0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_r_gaps();
    test_rresp_err();
    test_rlast_err();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
